// File: rtl/wrapper_vga_frontend_pkg.sv
// Shared VGA timing defaults (640x480@60), sync polarity constants and a width helper
// used by the front-end and its key debouncer.
package wrapper_vga_frontend_pkg;

  localparam int SYNC_NEG = 0;
  localparam int SYNC_POS = 1;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // A counter over 'count' states needs at least one bit even when count is 1.
  function automatic int width_for(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/wrapper_vga_frontend_key_debounce.sv
// One board key: two-flop synchroniser, optional inversion, stability debouncer and
// a single-clock press pulse on the accepted 0->1 transition.
module key_debounce
  import wrapper_vga_frontend_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter bit ACT_LOW    = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int CW = width_for(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          sync_raw;
  logic          synced;
  logic [CW-1:0] cnt;

  // Synchroniser flops rest at the idle key level so release from reset is not seen as a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta     <= ACT_LOW;
      sync_raw <= ACT_LOW;
    end else begin
      meta     <= key_raw;
      sync_raw <= meta;
    end
  end

  assign synced = sync_raw ^ ACT_LOW;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        press <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrapper_vga_frontend.sv
// Board front-end for VGA game cores: pixel strobe divider, hpos/vpos timing, blanked and
// sync-aligned registered outputs, and debounced key inputs.
module wrapper_vga_frontend
  import wrapper_vga_frontend_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_DISPLAY   = DEF_H_DISPLAY,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_DISPLAY   = DEF_V_DISPLAY,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int SYNC_POL    = SYNC_NEG,
  parameter int RGB_W       = 3,
  parameter int KEYS        = 4,
  parameter int KEY_ACT_LOW = 0,
  parameter int DEB_CYCLES  = 16,
  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int HW    = $clog2(H_TOT),
  localparam int VW    = $clog2(V_TOT)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [KEYS-1:0]  keys_raw,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pix_en,
  output logic [HW-1:0]    hpos,
  output logic [VW-1:0]    vpos,
  output logic             display_on,
  output logic             frame_start,
  output logic [KEYS-1:0]  key_level,
  output logic [KEYS-1:0]  key_press,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
);

  localparam int DW = width_for(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [DW-1:0] div_cnt;
  logic          line_end;
  logic          frame_end;
  logic          h_sync_on;
  logic          v_sync_on;

  assign line_end   = (hpos == H_LAST);
  assign frame_end  = line_end && (vpos == V_LAST);
  assign display_on = (hpos < H_VIS) && (vpos < V_VIS);
  assign h_sync_on  = (hpos >= HS_FIRST) && (hpos <= HS_LAST);
  assign v_sync_on  = (vpos >= VS_FIRST) && (vpos <= VS_LAST);

  // pix_en is registered from the divider so it is low out of reset and first rises
  // on the CLK_DIV-th edge after release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      pix_en  <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hpos        <= '0;
      vpos        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_end;
      if (pix_en) begin
        if (line_end) begin
          hpos <= '0;
          vpos <= (vpos == V_LAST) ? '0 : vpos + 1'b1;
        end else begin
          hpos <= hpos + 1'b1;
        end
      end
    end
  end

  // Colour and both syncs are captured from the same pixel, giving one pixel of latency
  // with rgb and sync always aligned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rgb   <= '0;
      hsync <= ~SYNC_ACT;
      vsync <= ~SYNC_ACT;
    end else if (pix_en) begin
      rgb   <= display_on ? rgb_in : '0;
      hsync <= h_sync_on ? SYNC_ACT : ~SYNC_ACT;
      vsync <= v_sync_on ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  for (genvar i = 0; i < KEYS; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .ACT_LOW    (KEY_ACT_LOW != 0)
    ) u_key (
      .clk     (clk),
      .resetn  (resetn),
      .key_raw (keys_raw[i]),
      .level   (key_level[i]),
      .press   (key_press[i])
    );
  end

endmodule

// File: tb/tb_wrapper_vga_frontend.sv
// Directed bench: a default-timing instance (line timing, reset, active-high keys) and a
// tiny-timing instance (frame wrap, blanking, sync placement, active-low keys).
module tb_wrapper_vga_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [3:0] keys_a, keys_b;
  logic [2:0] rgb_in_a, rgb_in_b;

  logic       pix_en_a, display_on_a, frame_start_a, hsync_a, vsync_a;
  logic [9:0] hpos_a, vpos_a;
  logic [3:0] key_level_a, key_press_a;
  logic [2:0] rgb_a;

  logic       pix_en_b, display_on_b, frame_start_b, hsync_b, vsync_b;
  logic [3:0] hpos_b;
  logic [2:0] vpos_b;
  logic [3:0] key_level_b, key_press_b;
  logic [2:0] rgb_b;

  int checks = 0;
  int passes = 0;
  int press_cnt_a = 0;
  int press_cnt_b = 0;

  wrapper_vga_frontend #(.DEB_CYCLES(8)) dut_a (
    .clk(clk), .resetn(resetn), .keys_raw(keys_a), .rgb_in(rgb_in_a),
    .pix_en(pix_en_a), .hpos(hpos_a), .vpos(vpos_a), .display_on(display_on_a),
    .frame_start(frame_start_a), .key_level(key_level_a), .key_press(key_press_a),
    .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a)
  );

  wrapper_vga_frontend #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .KEY_ACT_LOW(1), .DEB_CYCLES(8)
  ) dut_b (
    .clk(clk), .resetn(resetn), .keys_raw(keys_b), .rgb_in(rgb_in_b),
    .pix_en(pix_en_b), .hpos(hpos_b), .vpos(vpos_b), .display_on(display_on_b),
    .frame_start(frame_start_b), .key_level(key_level_b), .key_press(key_press_b),
    .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    keys_a = a;
    keys_b = b;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      waitCycle();
      press_cnt_a += $countones(key_press_a);
      press_cnt_b += $countones(key_press_b);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int falls, rgb_fall_h, hs_fall_h, low_pix, t0, period, vpos_at, n;
    int frames, t1, hs_low, vs_low;
    logic [2:0] prev_rgb;
    logic prev_hs, done;
    logic [3:0] prev_h;
    logic [2:0] prev_v;

    resetn = 1'b0;
    applyStimulus(4'b0000, 4'b1111);
    rgb_in_a = 3'b111;
    rgb_in_b = 3'b111;
    repeat (3) waitCycle();
    resetn = 1'b1;

    // Default line timing
    falls = 0; rgb_fall_h = -1; hs_fall_h = -1; low_pix = 0; t0 = 0; period = 0; vpos_at = 0;
    prev_rgb = rgb_a; prev_hs = hsync_a;
    for (int c = 0; c < 6000 && falls < 2; c++) begin
      waitCycle();
      if (prev_rgb == 3'b111 && rgb_a == 3'b000 && rgb_fall_h < 0) rgb_fall_h = int'(hpos_a);
      if (prev_hs && !hsync_a) begin
        if (falls == 0) begin
          hs_fall_h = int'(hpos_a);
          t0 = c;
        end else begin
          period = c - t0;
          vpos_at = int'(vpos_a);
        end
        falls++;
      end
      if (falls == 1 && pix_en_a && !hsync_a) low_pix++;
      prev_rgb = rgb_a;
      prev_hs = hsync_a;
    end
    checkOutput("line_two_hsync_falls", falls, 2);
    checkOutput("rgb_blank_from_h640", rgb_fall_h, 641);
    checkOutput("hsync_fall_from_h656", hs_fall_h, 657);
    checkOutput("hsync_low_pixels", low_pix, 96);
    checkOutput("line_period_clk", period, 1600);
    checkOutput("vpos_after_line", vpos_at, 1);

    // Asynchronous reset mid-line
    n = 0;
    while (hpos_a != 10'd300 && n < 3000) begin
      waitCycle();
      n++;
    end
    checkOutput("reach_h300", 32'(n < 3000), 1);
    checkOutput("rgb_before_reset", 32'(rgb_a), 7);
    #2 resetn = 1'b0;
    #1;
    checkOutput("reset_hpos", 32'(hpos_a), 0);
    checkOutput("reset_vpos", 32'(vpos_a), 0);
    checkOutput("reset_pix_en", 32'(pix_en_a), 0);
    checkOutput("reset_rgb", 32'(rgb_a), 0);
    checkOutput("reset_hsync", 32'(hsync_a), 1);
    checkOutput("reset_vsync", 32'(vsync_a), 1);
    checkOutput("reset_frame_start", 32'(frame_start_a), 0);
    checkOutput("reset_display_on", 32'(display_on_a), 1);
    checkOutput("reset_key_level", 32'(key_level_a), 0);
    waitCycle();
    waitCycle();
    resetn = 1'b1;
    waitCycle();
    checkOutput("pix_en_a_edge1", 32'(pix_en_a), 0);
    checkOutput("pix_en_b_edge1", 32'(pix_en_b), 1);
    waitCycle();
    checkOutput("pix_en_a_edge2", 32'(pix_en_a), 1);
    waitCycle();
    checkOutput("pix_en_a_edge3", 32'(pix_en_a), 0);

    // Tiny timing frame
    frames = 0; t1 = 0; hs_low = 0; vs_low = 0; done = 1'b0;
    prev_h = hpos_b; prev_v = vpos_b;
    for (int c = 0; c < 400 && !done; c++) begin
      waitCycle();
      if (frames == 2) begin
        checkOutput("frame_start_width", 32'(frame_start_b), 0);
        done = 1'b1;
      end else if (frame_start_b) begin
        frames++;
        if (frames == 1) t1 = c;
        else begin
          checkOutput("frame_period_clk", c - t1, 98);
          checkOutput("vwrap_prev_v", 32'(prev_v), 6);
          checkOutput("vwrap_prev_h", 32'(prev_h), 13);
          checkOutput("vwrap_hpos", 32'(hpos_b), 0);
          checkOutput("vwrap_vpos", 32'(vpos_b), 0);
        end
      end
      if (frames == 1) begin
        if (!hsync_b) hs_low++;
        if (!vsync_b) vs_low++;
        if (prev_h == 4'd13 && prev_v == 3'd2) begin
          checkOutput("hwrap_hpos", 32'(hpos_b), 0);
          checkOutput("hwrap_vpos", 32'(vpos_b), 3);
        end
        if (hpos_b == 4'd1 && vpos_b == 3'd0) checkOutput("rgb_visible", 32'(rgb_b), 7);
        if (hpos_b == 4'd9 && vpos_b == 3'd0) checkOutput("rgb_hblank", 32'(rgb_b), 0);
        if (hpos_b == 4'd0 && vpos_b == 3'd1) checkOutput("rgb_latency_h13", 32'(rgb_b), 0);
        if (hpos_b == 4'd1 && vpos_b == 3'd1) checkOutput("rgb_latency_h0", 32'(rgb_b), 7);
        if (hpos_b == 4'd1 && vpos_b == 3'd4) checkOutput("rgb_vblank", 32'(rgb_b), 0);
        if (hpos_b == 4'd7 && vpos_b == 3'd3) checkOutput("disp_on_7_3", 32'(display_on_b), 1);
        if (hpos_b == 4'd8 && vpos_b == 3'd3) checkOutput("disp_on_8_3", 32'(display_on_b), 0);
        if (hpos_b == 4'd7 && vpos_b == 3'd4) checkOutput("disp_on_7_4", 32'(display_on_b), 0);
        if (hpos_b == 4'd10 && vpos_b == 3'd0) checkOutput("hsync_at_10", 32'(hsync_b), 1);
        if (hpos_b == 4'd11 && vpos_b == 3'd0) checkOutput("hsync_at_11", 32'(hsync_b), 0);
        if (hpos_b == 4'd13 && vpos_b == 3'd0) checkOutput("hsync_at_13", 32'(hsync_b), 1);
        if (hpos_b == 4'd0 && vpos_b == 3'd5) checkOutput("vsync_0_5", 32'(vsync_b), 1);
        if (hpos_b == 4'd1 && vpos_b == 3'd5) checkOutput("vsync_1_5", 32'(vsync_b), 0);
        if (hpos_b == 4'd0 && vpos_b == 3'd6) checkOutput("vsync_0_6", 32'(vsync_b), 0);
        if (hpos_b == 4'd1 && vpos_b == 3'd6) checkOutput("vsync_1_6", 32'(vsync_b), 1);
      end
      prev_h = hpos_b;
      prev_v = vpos_b;
    end
    checkOutput("frames_seen", frames, 2);
    checkOutput("tiny_hsync_low_clk", hs_low, 14);
    checkOutput("tiny_vsync_low_clk", vs_low, 14);

    // Debounce, active-high keys on dut_a
    press_cnt_a = 0;
    press_cnt_b = 0;
    applyStimulus(4'b0001, 4'b1111);
    runCycles(5);
    applyStimulus(4'b0000, 4'b1111);
    runCycles(15);
    checkOutput("glitch_level", 32'(key_level_a), 0);
    checkOutput("glitch_press", press_cnt_a, 0);

    applyStimulus(4'b0001, 4'b1111);
    runCycles(9);
    checkOutput("hold_level_raw9", 32'(key_level_a), 0);
    runCycles(1);
    checkOutput("hold_level_raw10", 32'(key_level_a), 1);
    checkOutput("hold_press_pulse", 32'(key_press_a), 1);
    runCycles(1);
    checkOutput("hold_press_width", 32'(key_press_a), 0);
    runCycles(5);
    checkOutput("hold_press_count", press_cnt_a, 1);

    applyStimulus(4'b0000, 4'b1111);
    runCycles(12);
    checkOutput("release_level", 32'(key_level_a), 0);
    checkOutput("release_no_press", press_cnt_a, 1);

    // Active-low keys on dut_b
    checkOutput("al_idle_level", 32'(key_level_b), 0);
    applyStimulus(4'b0000, 4'b1101);
    runCycles(9);
    checkOutput("al_level_raw9", 32'(key_level_b), 0);
    runCycles(1);
    checkOutput("al_level_raw10", 32'(key_level_b), 2);
    checkOutput("al_press_pulse", 32'(key_press_b), 2);
    runCycles(3);
    checkOutput("al_press_count", press_cnt_b, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
